// File: rtl/dlfloat16_pkg.sv
// Shared dlfloat16 constants, flag bit positions and scheduler types.
package dlfloat16_pkg;

  localparam int DLF_W      = 16;
  localparam int DLF_RES_W  = 20;
  localparam int DLF_FLAG_W = 5;

  localparam int DZ = 0;
  localparam int UF = 1;
  localparam int OF = 2;
  localparam int NX = 3;
  localparam int NV = 4;

  localparam logic [DLF_W-1:0] DLF_QNAN_POS = 16'h7E00;
  localparam logic [DLF_W-1:0] DLF_QNAN_NEG = 16'hFE00;
  localparam logic [DLF_W-1:0] DLF_ONE      = 16'h3E00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [DLF_RES_W-1:0]  c;
    logic [DLF_FLAG_W-1:0] flags;
  } dlf_rsp_t;

endpackage

// File: rtl/dlf_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module dlf_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/dlfloat16_div_sched.sv
// Round-robin front end sharing one dlfloat16 divider among NUM_REQ requesters;
// returns result, flags and requester ID, and accumulates sticky flags.
module dlfloat16_div_sched
  import dlfloat16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DLF_W*NUM_REQ-1:0]  req_a,
  input  logic [DLF_W*NUM_REQ-1:0]  req_b,
  output logic [DLF_W-1:0]          div_a,
  output logic [DLF_W-1:0]          div_b,
  input  logic [DLF_RES_W-1:0]      div_c,
  input  logic [DLF_FLAG_W-1:0]     div_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DLF_RES_W-1:0]      rsp_c,
  output logic [DLF_FLAG_W-1:0]     rsp_flags,
  output logic [DLF_FLAG_W-1:0]     sticky_flags,
  input  logic                      flags_clr,
  output logic                      busy
);

  localparam int CNT_W = (DIV_LAT < 2) ? 1 : $clog2(DIV_LAT + 1);

  sched_state_e          state_q, state_d;
  logic [ID_W-1:0]       ptr_q, id_q, g_idx;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    gnt;
  logic                  g_any, grant_ok, do_grant, capture;
  logic [DLF_W-1:0]      div_a_q, div_b_q;
  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q;
  dlf_rsp_t              rsp_q;
  logic [DLF_FLAG_W-1:0] sticky_q;

  dlf_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (g_idx),
    .any_o (g_any)
  );

  // rst_n gates the handshake so req_ready reads zero while reset is held.
  always_comb begin
    grant_ok  = rst_n && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
    do_grant  = grant_ok && g_any;
    capture   = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
    req_ready = grant_ok ? gnt : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (do_grant) state_d = S_WAIT;
      S_WAIT:  if (capture)  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = do_grant ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q       <= '0;
      sticky_q    <= '0;
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        div_a_q <= req_a[int'(g_idx)*DLF_W +: DLF_W];
        div_b_q <= req_b[int'(g_idx)*DLF_W +: DLF_W];
        id_q    <= g_idx;
        ptr_q   <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
        cnt_q   <= CNT_W'(DIV_LAT);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_q.c     <= div_c;
        rsp_q.flags <= div_flags;
      end else if (state_q == S_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      // A clear coinciding with a capture keeps the freshly captured flags.
      if (capture)        sticky_q <= (flags_clr ? '0 : sticky_q) | div_flags;
      else if (flags_clr) sticky_q <= '0;
    end
  end

  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_c        = rsp_q.c;
  assign rsp_flags    = rsp_q.flags;
  assign sticky_flags = sticky_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dlfloat16_div_sched.sv
// Directed bench for dlfloat16_div_sched with a small divider stand-in.
module tb_dlfloat16_div_sched;
  import dlfloat16_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NR-1:0]         req_valid, req_ready;
  logic [16*NR-1:0]      req_a, req_b;
  logic [15:0]           div_a, div_b;
  logic [19:0]           div_c;
  logic [4:0]            div_flags;
  logic                  rsp_valid, rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [19:0]           rsp_c;
  logic [4:0]            rsp_flags, sticky_flags;
  logic                  flags_clr, busy;

  int n_chk = 0;
  int n_err = 0;

  dlfloat16_div_sched #(.NUM_REQ(NR), .DIV_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .div_a(div_a), .div_b(div_b), .div_c(div_c), .div_flags(div_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider stand-in: results settle within one edge of a/b changing.
  always_comb begin
    if (div_b[14:0] == 15'h0) begin
      div_c     = 20'h7E000;
      div_flags = (div_a[14:0] == 15'h0) ? 5'b10000 : 5'b00001;
    end else if (div_a == 16'h3E00 && div_b == 16'h3E00) begin
      div_c     = 20'h3E000;
      div_flags = 5'b00000;
    end else begin
      div_c     = {div_a, 4'h0};
      div_flags = 5'b00000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       bp_ok;
    logic [15:0] rr_a;
    int         g;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; flags_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",  req_ready, 0);
    chk("rst_div_a",  div_a, 0);
    chk("rst_rsp_v",  rsp_valid, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_sticky", sticky_flags, 0);
    @(negedge clk); rst_n = 1'b1;

    // single op from requester 2
    set_op(2, 16'h3E00, 16'h3E00); req_valid = 4'b0100;
    #1 chk("one_ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    #1 chk("one_ready_lo", req_ready, 0);
    chk("one_busy", busy, 1);
    chk("one_div_a", div_a, 16'h3E00);
    chk("one_rsp_v0", rsp_valid, 0);
    @(negedge clk);
    chk("one_rsp_v", rsp_valid, 1);
    chk("one_id", rsp_id, 2);
    chk("one_c", rsp_c, 20'h3E000);
    chk("one_flags", rsp_flags, 0);
    @(negedge clk);
    chk("one_done_v", rsp_valid, 0);
    chk("one_idle", busy, 0);

    // divide by zero from requester 0 (search wraps 3 -> 0)
    set_op(0, 16'h3E00, 16'h0000); req_valid = 4'b0001;
    #1 chk("dz_ready", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    chk("dz_id", rsp_id, 0);
    chk("dz_c", rsp_c, 20'h7E000);
    chk("dz_flags", rsp_flags, 5'b00001);
    chk("dz_sticky", sticky_flags, 5'b00001);
    flags_clr = 1'b1;
    @(negedge clk);
    chk("clr_sticky", sticky_flags, 0);
    chk("clr_rsp_v", rsp_valid, 0);
    flags_clr = 1'b0;

    // backpressure: req 3 result held while req 1 waits
    set_op(3, 16'h3E00, 16'h3E00); req_valid = 4'b1000; rsp_ready = 1'b0;
    #1 chk("bp_ready3", req_ready, 4'b1000);
    @(negedge clk);
    set_op(1, 16'h4000, 16'h0000); req_valid = 4'b0010;
    #1 chk("bp_wait_ready", req_ready, 0);
    @(negedge clk);
    bp_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!(rsp_valid === 1'b1 && rsp_id === 2'd3 && rsp_c === 20'h3E000 &&
            rsp_flags === 5'b0 && req_ready === 4'b0)) bp_ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", bp_ok, 1);
    chk("bp_id", rsp_id, 3);
    rsp_ready = 1'b1;
    #1 chk("bp_grant1", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0;
    chk("bp_b2b_v", rsp_valid, 0);
    chk("bp_b2b_busy", busy, 1);
    chk("bp_div_a", div_a, 16'h4000);
    @(negedge clk);
    chk("bp1_v", rsp_valid, 1);
    chk("bp1_id", rsp_id, 1);
    chk("bp1_flags", rsp_flags, 5'b00001);
    chk("bp1_sticky", sticky_flags, 5'b00001);

    // clear and capture on the same edge with a 0/0 op from requester 3
    set_op(3, 16'h0000, 16'h0000); req_valid = 4'b1000;
    #1 chk("col_ready", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0; flags_clr = 1'b1;
    @(negedge clk);
    chk("col_sticky", sticky_flags, 5'b10000);
    chk("col_flags", rsp_flags, 5'b10000);
    flags_clr = 1'b0;

    // round robin under full load, pointer back at 0
    for (int i = 0; i < NR; i++) set_op(i, 16'h4000 + 16'(i << 8), 16'h3E00);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % NR;
      rr_a = 16'h4000 + 16'(g << 8);
      #1 chk($sformatf("rr%0d_ready", k), req_ready, 32'(1 << g));
      @(negedge clk);
      chk($sformatf("rr%0d_gap", k), rsp_valid, 0);
      @(negedge clk);
      chk($sformatf("rr%0d_v", k), rsp_valid, 1);
      chk($sformatf("rr%0d_id", k), rsp_id, g);
      chk($sformatf("rr%0d_c", k), rsp_c, {rr_a, 4'h0});
    end
    req_valid = '0;
    @(negedge clk);

    // reset during WAIT discards the op and rewinds the pointer
    set_op(2, 16'h3E00, 16'h3E00); req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_rsp_v", rsp_valid, 0);
    chk("rmid_div_a", div_a, 0);
    chk("rmid_ready", req_ready, 0);
    chk("rmid_sticky", sticky_flags, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rpost_ready", req_ready, 4'b0001);
    chk("rpost_rsp_v", rsp_valid, 0);
    @(negedge clk); req_valid = '0;
    chk("rpost_wait_v", rsp_valid, 0);
    @(negedge clk);
    chk("rpost_v", rsp_valid, 1);
    chk("rpost_id", rsp_id, 0);
    chk("rpost_c", rsp_c, 20'h40000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
